match_flow_ctl: RTL and testbench
=================================

Name: match_flow_ctl

Overview:
- Match sequencer for the pong datapath. Decides when the ball controller holds the ball at centre, when it runs, and which player it is served toward.
- Owns both 2-bit scores, the pre-serve countdown, the post-point pause and the game-over condition.
- Sits between the input handlers (mouse_left start, button abort), the ball controller (miss events in, run/centre commands out) and the score/overlay renderer.

Parameters:
WIN_SCORE, 3, score that ends the match; range 1..3.
SERVE_FRAMES, 60, frame ticks per countdown step; range 1..255.
POINT_FRAMES, 90, frame ticks of pause after a point; range 1..255.

Ports:
pclk  in  1  pixel clock; only clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level input (mouse_left); only its rising edge is used.
abort  in  1  level input (button); returns to IDLE and clears scores.
frame_tick  in  1  one-cycle pulse per video frame.
miss_left  in  1  one-cycle pulse: ball passed the left wall, point to p2.
miss_right  in  1  one-cycle pulse: ball passed the right wall, point to p1.
ball_run  out  1  ball controller may move the ball.
ball_center  out  1  ball controller holds the ball at the central line.
serve_left  out  1  1 = next serve travels toward the left player.
score_p1  out  2  player-1 score.
score_p2  out  2  player-2 score.
countdown  out  2  countdown digit for the overlay; 0 when not counting.
game_over  out  1  match finished.
winner  out  1  0 = p1 won, 1 = p2 won; valid while game_over = 1.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE; start edge register = 0; frame counter = 0.
  - ball_center = 1; serve_left = 1.
  - All other outputs = 0.
- Timing:
  - Every output is a register updated on the same pclk edge as the state.
  - An output reacts exactly 1 cycle after the input that triggers it is sampled.
- Start edge: start_rise = start & ~start_q. start_q is updated every cycle. A start held high through reset release produces no edge.
- Priority: abort outranks every transition, from any state.
  - Next cycle: IDLE, both scores = 0, countdown = 0, game_over = 0.
- States:
  - IDLE: ball_run = 0, ball_center = 1. start_rise -> COUNTDOWN, scores cleared, countdown = 3, frame counter = 0.
  - COUNTDOWN: ball_run = 0, ball_center = 1.
    - Each frame_tick increments the frame counter.
    - When the counter reaches SERVE_FRAMES: counter = 0 and countdown decrements.
    - The decrement from 1 to 0 moves to RALLY in the same cycle.
    - Total duration is 3*SERVE_FRAMES frame ticks.
  - RALLY: ball_run = 1, ball_center = 0, countdown = 0.
    - miss_left only: score_p2 + 1, serve_left = 1.
    - miss_right only: score_p1 + 1, serve_left = 0.
    - If the new score equals WIN_SCORE -> OVER. winner = 1 for p2, 0 for p1.
    - Otherwise -> POINT with frame counter = 0.
    - miss_left and miss_right in the same cycle: no score change, serve_left unchanged, -> COUNTDOWN with countdown = 3.
  - POINT: ball_run = 0, ball_center = 1. After POINT_FRAMES frame ticks -> COUNTDOWN, countdown = 3, counter = 0.
  - OVER: game_over = 1, ball_run = 0, ball_center = 1, scores frozen.
    - start_rise -> COUNTDOWN with scores cleared, game_over = 0, serve_left = 1.
- Arithmetic:
  - Scores saturate at 3 and never wrap.
  - Frame counter is 8 bits and compared with ==.
- Ignored inputs:
  - miss_left and miss_right outside RALLY.
  - start_rise outside IDLE and OVER.
  - frame_tick outside COUNTDOWN and POINT.
- frame_tick coincident with a state entry is not counted.
- Reset mid-operation: immediate return to the reset values above, with no partial score update.

Test Plan (bench parameters SERVE_FRAMES = 2, POINT_FRAMES = 3, WIN_SCORE = 3):
1. Reset, then start rising edge -> next cycle COUNTDOWN, countdown = 3. After 2, 4 and 6 frame ticks countdown = 2, 1, then ball_run = 1 with countdown = 0.
2. In RALLY, pulse miss_right -> next cycle score_p1 = 1, serve_left = 0, ball_run = 0, ball_center = 1. After 3 frame ticks -> countdown = 3.
3. Score p2 three times via miss_left -> after the third point game_over = 1, winner = 1, score_p2 = 3. A further miss_left leaves score_p2 at 3.
4. miss_left and miss_right in the same cycle during RALLY -> scores unchanged, countdown = 3, ball_run = 0.
5. abort during POINT with score_p1 = 2 -> next cycle IDLE, scores 0, ball_center = 1. start held high with no edge -> stays in IDLE.
6. rst_n low mid-COUNTDOWN, asynchronously between clock edges -> outputs go to reset values immediately. Miss pulses in IDLE are ignored.

Source files
------------

// File: rtl/match_flow_ctl.sv
// Pong match sequencer: owns scores, serve direction, pre-serve countdown,
// post-point pause and game-over, and commands the ball controller.
module match_flow_ctl #(
    parameter int WIN_SCORE    = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_left,
    output logic [1:0] score_p1,
    output logic [1:0] score_p2,
    output logic [1:0] countdown,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RALLY     = 3'd2,
        ST_POINT     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LIM = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LIM = 8'(POINT_FRAMES);
    localparam logic [1:0] WIN_LIM   = 2'(WIN_SCORE);

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    state_t     state_r, state_s;
    logic       start_q_r;
    logic       armed_r;
    logic [7:0] frame_cnt_r, frame_cnt_s, cnt_inc_s;
    logic [1:0] p1_s, p2_s, p1_inc_s, p2_inc_s, cd_s;
    logic       serve_s, winner_s, start_rise_s;
    logic       ball_run_s, ball_center_s, game_over_s;

    // armed_r masks the first cycle after reset so a start held through release is not an edge
    assign start_rise_s = start & ~start_q_r & armed_r;
    assign cnt_inc_s    = frame_cnt_r + 8'd1;
    assign p1_inc_s     = sat_inc(score_p1);
    assign p2_inc_s     = sat_inc(score_p2);

    // Next-state and next-output decode; abort overrides every state
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        p1_s        = score_p1;
        p2_s        = score_p2;
        cd_s        = countdown;
        serve_s     = serve_left;
        winner_s    = winner;
        if (abort) begin
            state_s     = ST_IDLE;
            p1_s        = 2'd0;
            p2_s        = 2'd0;
            cd_s        = 2'd0;
            frame_cnt_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_s     = ST_COUNTDOWN;
                        p1_s        = 2'd0;
                        p2_s        = 2'd0;
                        cd_s        = 2'd3;
                        frame_cnt_s = 8'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_COUNTDOWN: begin
                    if (frame_tick) begin
                        if (cnt_inc_s == SERVE_LIM) begin
                            frame_cnt_s = 8'd0;
                            cd_s        = countdown - 2'd1;
                            if (countdown == 2'd1) begin
                                state_s = ST_RALLY;
                            end else begin
                                state_s = ST_COUNTDOWN;
                            end
                        end else begin
                            frame_cnt_s = cnt_inc_s;
                        end
                    end else begin
                        frame_cnt_s = frame_cnt_r;
                    end
                end
                ST_RALLY: begin
                    cd_s = 2'd0;
                    case ({miss_left, miss_right})
                        2'b10: begin
                            p2_s        = p2_inc_s;
                            serve_s     = 1'b1;
                            frame_cnt_s = 8'd0;
                            if (p2_inc_s == WIN_LIM) begin
                                state_s  = ST_OVER;
                                winner_s = 1'b1;
                            end else begin
                                state_s = ST_POINT;
                            end
                        end
                        2'b01: begin
                            p1_s        = p1_inc_s;
                            serve_s     = 1'b0;
                            frame_cnt_s = 8'd0;
                            if (p1_inc_s == WIN_LIM) begin
                                state_s  = ST_OVER;
                                winner_s = 1'b0;
                            end else begin
                                state_s = ST_POINT;
                            end
                        end
                        2'b11: begin
                            state_s     = ST_COUNTDOWN;
                            cd_s        = 2'd3;
                            frame_cnt_s = 8'd0;
                        end
                        default: begin
                            state_s = ST_RALLY;
                        end
                    endcase
                end
                ST_POINT: begin
                    if (frame_tick) begin
                        if (cnt_inc_s == POINT_LIM) begin
                            state_s     = ST_COUNTDOWN;
                            cd_s        = 2'd3;
                            frame_cnt_s = 8'd0;
                        end else begin
                            frame_cnt_s = cnt_inc_s;
                        end
                    end else begin
                        frame_cnt_s = frame_cnt_r;
                    end
                end
                ST_OVER: begin
                    if (start_rise_s) begin
                        state_s     = ST_COUNTDOWN;
                        p1_s        = 2'd0;
                        p2_s        = 2'd0;
                        serve_s     = 1'b1;
                        cd_s        = 2'd3;
                        frame_cnt_s = 8'd0;
                    end else begin
                        state_s = ST_OVER;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    cd_s        = 2'd0;
                    frame_cnt_s = 8'd0;
                end
            endcase
        end
        ball_run_s    = (state_s == ST_RALLY);
        ball_center_s = (state_s != ST_RALLY);
        game_over_s   = (state_s == ST_OVER);
    end

    // State, counters and all outputs registered together
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            start_q_r   <= 1'b0;
            armed_r     <= 1'b0;
            frame_cnt_r <= 8'd0;
            ball_run    <= 1'b0;
            ball_center <= 1'b1;
            serve_left  <= 1'b1;
            score_p1    <= 2'd0;
            score_p2    <= 2'd0;
            countdown   <= 2'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            state_r     <= state_s;
            start_q_r   <= start;
            armed_r     <= 1'b1;
            frame_cnt_r <= frame_cnt_s;
            ball_run    <= ball_run_s;
            ball_center <= ball_center_s;
            serve_left  <= serve_s;
            score_p1    <= p1_s;
            score_p2    <= p2_s;
            countdown   <= cd_s;
            game_over   <= game_over_s;
            winner      <= winner_s;
        end
    end

endmodule

// File: tb/tb_match_flow_ctl.sv
// Bench for match_flow_ctl: directed test-plan sequence followed by random
// stimulus, all checked against a phase/tick-count reference model.
module tb_match_flow_ctl;

    localparam int SF = 2;
    localparam int PF = 3;
    localparam int WS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_CD    = 1;
    localparam int M_RALLY = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run, ball_center, serve_left, game_over, winner;
    logic [1:0] score_p1, score_p2, countdown;

    int n_tests = 0;
    int n_fail  = 0;

    // model: current phase, scores, and frame ticks counted within the phase
    int   m_mode, m_p1, m_p2, m_ticks;
    logic m_serve, m_winner, m_prev_start, m_armed;

    match_flow_ctl #(.WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .abort(abort),
        .frame_tick(frame_tick), .miss_left(miss_left), .miss_right(miss_right),
        .ball_run(ball_run), .ball_center(ball_center), .serve_left(serve_left),
        .score_p1(score_p1), .score_p2(score_p2), .countdown(countdown),
        .game_over(game_over), .winner(winner)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_ticks = 0;
        m_serve = 1'b1; m_winner = 1'b0; m_prev_start = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_point(input bit to_p2);
        if (to_p2) begin
            m_p2 = (m_p2 + 1 > 3) ? 3 : m_p2 + 1;
            m_serve = 1'b1;
        end else begin
            m_p1 = (m_p1 + 1 > 3) ? 3 : m_p1 + 1;
            m_serve = 1'b0;
        end
        m_ticks = 0;
        if ((to_p2 ? m_p2 : m_p1) == WS) begin
            m_mode = M_OVER;
            m_winner = to_p2;
        end else begin
            m_mode = M_POINT;
        end
    endtask

    task automatic model_step();
        bit rise;
        rise = start && !m_prev_start && m_armed;
        m_prev_start = start;
        m_armed = 1'b1;
        if (abort) begin
            m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_ticks = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (rise) begin m_mode = M_CD; m_p1 = 0; m_p2 = 0; m_ticks = 0; end
                M_CD: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == 3 * SF) m_mode = M_RALLY;
                end
                M_RALLY: begin
                    if (miss_left && miss_right) begin m_mode = M_CD; m_ticks = 0; end
                    else if (miss_left) model_point(1'b1);
                    else if (miss_right) model_point(1'b0);
                end
                M_POINT: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == PF) begin m_mode = M_CD; m_ticks = 0; end
                end
                M_OVER: if (rise) begin
                    m_mode = M_CD; m_p1 = 0; m_p2 = 0; m_serve = 1'b1; m_ticks = 0;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        check_val("ball_run", 8'(ball_run), 8'(m_mode == M_RALLY));
        check_val("ball_center", 8'(ball_center), 8'(m_mode != M_RALLY));
        check_val("serve_left", 8'(serve_left), 8'(m_serve));
        check_val("score_p1", 8'(score_p1), 8'(m_p1));
        check_val("score_p2", 8'(score_p2), 8'(m_p2));
        check_val("countdown", 8'(countdown), 8'((m_mode == M_CD) ? 3 - m_ticks / SF : 0));
        check_val("game_over", 8'(game_over), 8'(m_mode == M_OVER));
        if (m_mode == M_OVER) check_val("winner", 8'(winner), 8'(m_winner));
    endtask

    task automatic drive_cycle(input logic t, input logic ml, input logic mr,
                               input logic st, input logic ab);
        frame_tick = t; miss_left = ml; miss_right = mr; start = st; abort = ab;
        @(posedge pclk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_center"}, 8'(ball_center), 8'd1);
        check_val({tag, "_serve"}, 8'(serve_left), 8'd1);
        check_val({tag, "_run"}, 8'(ball_run), 8'd0);
        check_val({tag, "_p1"}, 8'(score_p1), 8'd0);
        check_val({tag, "_p2"}, 8'(score_p2), 8'd0);
        check_val({tag, "_cd"}, 8'(countdown), 8'd0);
        check_val({tag, "_over"}, 8'(game_over), 8'd0);
        check_val({tag, "_winner"}, 8'(winner), 8'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        drive_cycle(0, 0, 0, 0, 0);

        // 1: start edge and full countdown
        drive_cycle(0, 0, 0, 1, 0);
        check_val("t1_cd3", 8'(countdown), 8'd3);
        repeat (2) drive_cycle(1, 0, 0, 1, 0);
        check_val("t1_cd2", 8'(countdown), 8'd2);
        repeat (2) drive_cycle(1, 0, 0, 1, 0);
        check_val("t1_cd1", 8'(countdown), 8'd1);
        repeat (2) drive_cycle(1, 0, 0, 1, 0);
        check_val("t1_run", 8'(ball_run), 8'd1);
        check_val("t1_cd0", 8'(countdown), 8'd0);

        // 2: point to p1 and pause
        drive_cycle(0, 0, 1, 1, 0);
        check_val("t2_p1", 8'(score_p1), 8'd1);
        check_val("t2_serve", 8'(serve_left), 8'd0);
        check_val("t2_run", 8'(ball_run), 8'd0);
        check_val("t2_center", 8'(ball_center), 8'd1);
        repeat (3) drive_cycle(1, 0, 0, 1, 0);
        check_val("t2_cd3", 8'(countdown), 8'd3);

        // 3: p2 wins with three points, then saturation/freeze
        for (int i = 0; i < 3; i++) begin
            repeat (6) drive_cycle(1, 0, 0, 1, 0);
            drive_cycle(0, 1, 0, 1, 0);
            if (i < 2) repeat (3) drive_cycle(1, 0, 0, 1, 0);
        end
        check_val("t3_over", 8'(game_over), 8'd1);
        check_val("t3_winner", 8'(winner), 8'd1);
        check_val("t3_p2", 8'(score_p2), 8'd3);
        drive_cycle(0, 1, 0, 1, 0);
        check_val("t3_p2_sat", 8'(score_p2), 8'd3);

        // 4: simultaneous misses
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0);
        check_val("t4_restart_over", 8'(game_over), 8'd0);
        repeat (6) drive_cycle(1, 0, 0, 1, 0);
        drive_cycle(0, 1, 1, 1, 0);
        check_val("t4_cd3", 8'(countdown), 8'd3);
        check_val("t4_run", 8'(ball_run), 8'd0);
        check_val("t4_p1", 8'(score_p1), 8'd0);
        check_val("t4_p2", 8'(score_p2), 8'd0);

        // 5: abort during POINT with p1 = 2, start held without edge
        repeat (6) drive_cycle(1, 0, 0, 1, 0);
        drive_cycle(0, 0, 1, 1, 0);
        repeat (3) drive_cycle(1, 0, 0, 1, 0);
        repeat (6) drive_cycle(1, 0, 0, 1, 0);
        drive_cycle(0, 0, 1, 1, 0);
        check_val("t5_p1_2", 8'(score_p1), 8'd2);
        drive_cycle(1, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1, 1);
        check_val("t5_p1", 8'(score_p1), 8'd0);
        check_val("t5_center", 8'(ball_center), 8'd1);
        repeat (3) drive_cycle(1, 0, 0, 1, 0);
        check_val("t5_idle_cd", 8'(countdown), 8'd0);

        // 6: asynchronous reset mid-countdown, then misses ignored in IDLE
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(1, 0, 0, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        model_reset();
        start = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        drive_cycle(0, 1, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0);
        drive_cycle(0, 1, 1, 0, 0);
        check_val("t6_p1", 8'(score_p1), 8'd0);
        check_val("t6_p2", 8'(score_p2), 8'd0);
        check_val("t6_run", 8'(ball_run), 8'd0);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            logic st;
            st = ($urandom_range(0, 3) == 0) ? ~start : start;
            drive_cycle(1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 7) == 0),
                        st,
                        1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
